stack_memory_controller: RTL and testbench
==========================================

# stack_memory_controller

Sequencer placed in the memory stage between the pipeline and the 2^11 x 16-bit data/stack memory. It owns the stack pointer, executes single-cycle LOAD/STORE/PUSH/POP, and splits 32-bit CALL/RET program-counter transfers into two 16-bit memory accesses. While a two-word transfer is in progress it back-pressures the pipeline through a valid/ready handshake.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDR_WIDTH, 32, memory address / PC width
- NUM_OF_REGISTER, 11, log2 of memory depth
- SP_RESET, 2**NUM_OF_REGISTER-1 (2047), stack pointer value after reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- op_valid  input  1  operation request
- op_ready  output  1  controller can accept an operation this cycle
- op_code  input  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET; 7 treated as NOP
- op_addr  input  ADDR_WIDTH  LOAD/STORE address
- op_wdata  input  DATA_WIDTH  STORE/PUSH data
- op_pc  input  ADDR_WIDTH  CALL return address
- rd_data  output  DATA_WIDTH  LOAD/POP result, registered
- rd_valid  output  1  one-cycle pulse: rd_data is valid
- pc_out  output  ADDR_WIDTH  RET target, registered
- pc_valid  output  1  one-cycle pulse: pc_out is valid
- sp_out  output  NUM_OF_REGISTER  current stack pointer
- err_overflow  output  1  one-cycle pulse: push/call rejected
- err_underflow  output  1  one-cycle pulse: pop/ret rejected
- mem_write_enable, mem_read_enable  output  1  memory strobes
- mem_address  output  ADDR_WIDTH  memory address; SP values are zero-extended
- mem_write_data  output  DATA_WIDTH  memory write data
- mem_read_data  input  DATA_WIDTH  memory read data; combinational w.r.t. mem_address

## Operation
- Stack is empty-descending: SP points to the next free word. Stack memory grows toward address 0.
- Handshake: an operation is accepted on a rising edge where op_valid && op_ready. op_ready = (state==IDLE) && rst.
- States: IDLE, CALL_LO, RET_HI.
- In IDLE, memory strobes are driven combinationally from the op_* inputs. The memory therefore writes on the falling edge of the acceptance cycle.
- LOAD: read op_addr. rd_data <= mem_read_data.
- STORE: write op_wdata to op_addr.
- PUSH: write op_wdata to SP, then SP <= SP-1.
- POP: read SP+1, then SP <= SP+1 and rd_data <= mem_read_data.
- CALL:
  - Acceptance cycle writes op_pc[31:16] at SP and latches op_pc[15:0]; SP <= SP-1; go to CALL_LO.
  - CALL_LO writes the latched low half at SP; SP <= SP-1; go to IDLE.
- RET:
  - Acceptance cycle reads SP+1 and latches the low half; go to RET_HI.
  - RET_HI reads SP+2; pc_out <= {mem_read_data, low}; SP <= SP+2; go to IDLE.
- NOP, or no accepted op: both strobes 0, mem_address 0, mem_write_data 0.
- SP arithmetic is modulo 2^NUM_OF_REGISTER.
- Bounds rejects (only with the macro enabled):
  - PUSH when SP==0, or CALL when SP<=1 → err_overflow.
  - POP when SP==SP_RESET, or RET when SP>=SP_RESET-1 → err_underflow.
  - A rejected op is consumed: no strobe, SP unchanged, no rd_valid/pc_valid, state stays IDLE.

## Timing
- Reset values: state IDLE, SP=SP_RESET, rd_data 0, pc_out 0, and rd_valid, pc_valid, err_* all 0.
- While rst is low, op_ready and both memory strobes are 0.
- LOAD/POP: rd_valid is high in the cycle after acceptance. Throughput is one op per cycle.
- CALL: occupies 2 cycles; op_ready is low for 1 cycle.
- RET: occupies 2 cycles; pc_valid is high in the cycle after RET_HI.
- Error pulses are high in the cycle after acceptance.
- rd_valid, pc_valid and err_* pulse for exactly one cycle and never overlap each other.
- Reset during CALL_LO: abort. The high word is already written and stays in memory; the low word is not written. SP returns to SP_RESET.
- Reset during RET_HI: abort; pc_valid is not asserted.
- op_valid while op_ready is low: ignored. The requester holds the op stable.

## Configuration
- STACK_BOUNDS_CHECK_EN defined: the overflow/underflow rejects above are active.
- Not defined:
  - No checks; err_overflow and err_underflow are tied to 0.
  - PUSH at SP==0 writes address 0 and SP wraps to 2047.
  - POP at SP==2047 reads address 0 and SP becomes 0.

## Test plan
- Reset, then PUSH 0x1234 and PUSH 0xABCD: memory[2047]=0x1234, [2046]=0xABCD, sp_out=2045. Then POP, POP: rd_data 0xABCD then 0x1234, each with a one-cycle rd_valid; sp_out=2047.
- CALL op_pc=0x0001_0234: [2047]=0x0001, [2046]=0x0234, op_ready low 1 cycle, sp_out=2045. Then RET: pc_out=0x0001_0234 with pc_valid 2 cycles after acceptance; sp_out=2047.
- STORE 0x5555 to 0x10, then LOAD 0x10 back-to-back: rd_data=0x5555 one cycle after the LOAD is accepted; sp_out unchanged.
- With the macro defined, POP right after reset: err_underflow pulses, no read strobe, sp_out=2047. With the macro undefined: sp_out=0, no error.
- Drive SP to 1 with the macro defined, then CALL: err_overflow pulses, no write, sp_out=1.
- Assert rst in the CALL_LO cycle: [2047] holds the high word, [2046] is untouched, sp_out=2047, op_ready high one cycle after rst is released.

Source files
------------

// File: rtl/stack_memory_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stack_memory_controller
//
// Memory-stage sequencer between the pipeline and a 2^NUM_OF_REGISTER x
// DATA_WIDTH data/stack memory. It owns the stack pointer (empty-descending:
// SP points at the next free word), executes single-cycle LOAD/STORE/PUSH/POP,
// and splits 32-bit CALL/RET program-counter transfers into two 16-bit memory
// accesses. A two-word transfer back-pressures the pipeline via op_ready.
//
// Optional feature macro: STACK_BOUNDS_CHECK_EN
//   defined   : PUSH/CALL past the bottom and POP/RET past the top are
//               rejected and reported on err_overflow / err_underflow.
//   undefined : no checks, SP wraps modulo 2^NUM_OF_REGISTER, err_* tied 0.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   op_valid/op_ready   request handshake (accept on op_valid && op_ready)
//   op_code             0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET
//   op_addr, op_wdata   LOAD/STORE address, STORE/PUSH data
//   op_pc               CALL return address
//   rd_data/rd_valid    registered LOAD/POP result + one-cycle pulse
//   pc_out/pc_valid     registered RET target + one-cycle pulse
//   sp_out              current stack pointer
//   err_overflow/underflow  one-cycle reject pulses
//   mem_*               memory strobes/address/data; mem_read_data is
//                       combinational with respect to mem_address
// -----------------------------------------------------------------------------
module stack_memory_controller #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_OF_REGISTER = 11,
  parameter int SP_RESET        = 2**NUM_OF_REGISTER - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op_code,
  input  logic [ADDR_WIDTH-1:0]      op_addr,
  input  logic [DATA_WIDTH-1:0]      op_wdata,
  input  logic [ADDR_WIDTH-1:0]      op_pc,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic [ADDR_WIDTH-1:0]      pc_out,
  output logic                       pc_valid,
  output logic [NUM_OF_REGISTER-1:0] sp_out,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       mem_write_enable,
  output logic                       mem_read_enable,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic [DATA_WIDTH-1:0]      mem_write_data,
  input  logic [DATA_WIDTH-1:0]      mem_read_data
);

  typedef logic [NUM_OF_REGISTER-1:0] sp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALL_LO = 2'd1,
    RET_HI  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam int  SP_RESET_W = SP_RESET;
  localparam sp_t SP_RST     = SP_RESET_W[NUM_OF_REGISTER-1:0];
  localparam sp_t SP_ONE     = sp_t'(1);
  localparam sp_t SP_TWO     = sp_t'(2);

  // SP values go onto the wider memory address bus zero-extended.
  function automatic logic [ADDR_WIDTH-1:0] zext(input sp_t sp);
    return {{(ADDR_WIDTH-NUM_OF_REGISTER){1'b0}}, sp};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q,     state_d;
  sp_t                   sp_q,        sp_d;
  logic [DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic [ADDR_WIDTH-1:0] pc_out_q,    pc_out_d;
  logic                  pc_valid_q,  pc_valid_d;
  logic                  err_ovf_q,   err_ovf_d;
  logic                  err_unf_q,   err_unf_d;
  // Low half of the PC: latched from op_pc on CALL, from memory on RET.
  logic [DATA_WIDTH-1:0] lo_q,        lo_d;

  op_e  op;
  logic accept;
  logic ovf_hit;
  logic unf_hit;
  sp_t  sp_p1;
  sp_t  sp_p2;
  sp_t  sp_m1;

  assign op       = op_e'(op_code);
  assign op_ready = (state_q == IDLE) && rst;
  assign accept   = op_valid && op_ready;

  // SP arithmetic is modulo 2^NUM_OF_REGISTER by virtue of the sp_t width.
  assign sp_p1 = sp_q + SP_ONE;
  assign sp_p2 = sp_q + SP_TWO;
  assign sp_m1 = sp_q - SP_ONE;

  // ---------------------------------------------------------------------------
  // Bounds checks
  // ---------------------------------------------------------------------------
`ifdef STACK_BOUNDS_CHECK_EN
  always_comb begin
    ovf_hit = ((op == OP_PUSH) && (sp_q == '0)) ||
              ((op == OP_CALL) && (sp_q <= SP_ONE));
    unf_hit = ((op == OP_POP)  && (sp_q == SP_RST)) ||
              ((op == OP_RET)  && (sp_q >= SP_RST - SP_ONE));
  end
`else
  assign ovf_hit = 1'b0;
  assign unf_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state, memory strobes and result capture
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d          = state_q;
    sp_d             = sp_q;
    rd_data_d        = rd_data_q;
    pc_out_d         = pc_out_q;
    lo_d             = lo_q;
    rd_valid_d       = 1'b0;
    pc_valid_d       = 1'b0;
    err_ovf_d        = 1'b0;
    err_unf_d        = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ovf_hit) begin
            // Rejected ops are consumed with no memory or SP side effects.
            err_ovf_d = 1'b1;
          end else if (unf_hit) begin
            err_unf_d = 1'b1;
          end else begin
            unique case (op)
              OP_LOAD: begin
                mem_read_enable = 1'b1;
                mem_address     = op_addr;
                rd_data_d       = mem_read_data;
                rd_valid_d      = 1'b1;
              end
              OP_STORE: begin
                mem_write_enable = 1'b1;
                mem_address      = op_addr;
                mem_write_data   = op_wdata;
              end
              OP_PUSH: begin
                mem_write_enable = 1'b1;
                mem_address      = zext(sp_q);
                mem_write_data   = op_wdata;
                sp_d             = sp_m1;
              end
              OP_POP: begin
                mem_read_enable = 1'b1;
                mem_address     = zext(sp_p1);
                rd_data_d       = mem_read_data;
                rd_valid_d      = 1'b1;
                sp_d            = sp_p1;
              end
              OP_CALL: begin
                // High half goes deeper in the stack so RET finds the low
                // half first at SP+1.
                mem_write_enable = 1'b1;
                mem_address      = zext(sp_q);
                mem_write_data   = op_pc[ADDR_WIDTH-1 -: DATA_WIDTH];
                lo_d             = op_pc[DATA_WIDTH-1:0];
                sp_d             = sp_m1;
                state_d          = CALL_LO;
              end
              OP_RET: begin
                // SP is left alone here; RET_HI still addresses from it.
                mem_read_enable = 1'b1;
                mem_address     = zext(sp_p1);
                lo_d            = mem_read_data;
                state_d         = RET_HI;
              end
              default: ;  // NOP and the reserved code do nothing
            endcase
          end
        end
      end

      CALL_LO: begin
        // Gating with rst keeps a reset in this cycle from writing the low
        // word; the flops below handle the rest of the abort.
        if (rst) begin
          mem_write_enable = 1'b1;
          mem_address      = zext(sp_q);
          mem_write_data   = lo_q;
        end
        sp_d    = sp_m1;
        state_d = IDLE;
      end

      RET_HI: begin
        if (rst) begin
          mem_read_enable = 1'b1;
          mem_address     = zext(sp_p2);
        end
        pc_out_d   = {mem_read_data, lo_q};
        pc_valid_d = 1'b1;
        sp_d       = sp_p2;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: rst is sampled only on the clock edge (synchronous reset), and all
  // state is updated with non-blocking assignments so every flop sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sp_q       <= SP_RST;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      pc_out_q   <= '0;
      pc_valid_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      pc_out_q   <= pc_out_d;
      pc_valid_q <= pc_valid_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      lo_q       <= lo_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign pc_out        = pc_out_q;
  assign pc_valid      = pc_valid_q;
  assign sp_out        = sp_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_stack_memory_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_stack_memory_controller
//
// Directed bench for stack_memory_controller with a 2048 x 16 memory model
// that writes on the falling clock edge and reads combinationally. Inputs
// change 1 ns after the rising edge; registered outputs are sampled at that
// point and combinational strobes 1 ns later.
// -----------------------------------------------------------------------------
module tb_stack_memory_controller;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NR = 11;

  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] STORE = 3'd2;
  localparam logic [2:0] PUSH  = 3'd3;
  localparam logic [2:0] POP   = 3'd4;
  localparam logic [2:0] CALL  = 3'd5;
  localparam logic [2:0] RET   = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [2:0]    op_code = NOP;
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_wdata = '0;
  logic [AW-1:0] op_pc = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] pc_out;
  logic          pc_valid;
  logic [NR-1:0] sp_out;
  logic          err_overflow;
  logic          err_underflow;
  logic          mem_write_enable;
  logic          mem_read_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stack_memory_controller dut (
    .clk              (clk),
    .rst              (rst),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_code          (op_code),
    .op_addr          (op_addr),
    .op_wdata         (op_wdata),
    .op_pc            (op_pc),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .pc_out           (pc_out),
    .pc_valid         (pc_valid),
    .sp_out           (sp_out),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Memory model
  logic [DW-1:0] mem [0:2047];
  always @(negedge clk) if (mem_write_enable) mem[mem_address[10:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[10:0]];

  // Stimulus helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [AW-1:0] p);
    op_valid = 1'b1;
    op_code  = c;
    op_addr  = a;
    op_wdata = d;
    op_pc    = p;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op_code  = NOP;
    op_addr  = '0;
    op_wdata = '0;
    op_pc    = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    idle_in();
    drive(PUSH, '0, 16'hFFFF, '0);  // must be ignored while in reset
    cyc();
    cyc();
    #1;
    n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready: got %b want 0", op_ready); end
    n_checks++; if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got we=%b re=%b want 0/0", mem_write_enable, mem_read_enable); end
    n_checks++; if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL reset_sp: got %0d want 2047", sp_out); end
    n_checks++; if (rd_data !== 16'h0 || pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got rd=%h pc=%h want 0/0", rd_data, pc_out); end
    n_checks++; if ({rd_valid, pc_valid, err_overflow, err_underflow} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0000", {rd_valid, pc_valid, err_overflow, err_underflow}); end
    idle_in();
    cyc();
    rst = 1'b1;
    #1;
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", op_ready); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_push_pop();
    drive(PUSH, '0, 16'h1234, '0);
    #1;
    n_checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'd2047 || mem_write_data !== 16'h1234) begin n_fail++; $display("FAIL push1_strobe: got we=%b a=%0d d=%h want 1/2047/1234", mem_write_enable, mem_address, mem_write_data); end
    cyc();
    drive(PUSH, '0, 16'hABCD, '0);
    #1;
    n_checks++; if (mem_address !== 32'd2046) begin n_fail++; $display("FAIL push2_addr: got %0d want 2046", mem_address); end
    cyc();
    n_checks++; if (mem[2047] !== 16'h1234 || mem[2046] !== 16'hABCD) begin n_fail++; $display("FAIL push_mem: got [2047]=%h [2046]=%h want 1234/abcd", mem[2047], mem[2046]); end
    n_checks++; if (sp_out !== 11'd2045) begin n_fail++; $display("FAIL push_sp: got %0d want 2045", sp_out); end
    drive(POP, '0, '0, '0);
    #1;
    n_checks++; if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_address !== 32'd2046) begin n_fail++; $display("FAIL pop1_strobe: got re=%b we=%b a=%0d want 1/0/2046", mem_read_enable, mem_write_enable, mem_address); end
    cyc();
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hABCD) begin n_fail++; $display("FAIL pop1_data: got v=%b d=%h want 1/abcd", rd_valid, rd_data); end
    cyc();
    idle_in();
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin n_fail++; $display("FAIL pop2_data: got v=%b d=%h want 1/1234", rd_valid, rd_data); end
    n_checks++; if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL pop_sp: got %0d want 2047", sp_out); end
    cyc();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL pop_valid_pulse: got %b want 0", rd_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_call_ret();
    drive(CALL, '0, '0, 32'h0001_0234);
    #1;
    n_checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'd2047 || mem_write_data !== 16'h0001) begin n_fail++; $display("FAIL call_hi_strobe: got we=%b a=%0d d=%h want 1/2047/0001", mem_write_enable, mem_address, mem_write_data); end
    cyc();
    n_checks++; if (op_ready !== 1'b0) begin n_fail++; $display("FAIL call_lo_ready: got %b want 0", op_ready); end
    // Holding a different request here must be ignored.
    drive(PUSH, '0, 16'hEEEE, '0);
    #1;
    n_checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'd2046 || mem_write_data !== 16'h0234) begin n_fail++; $display("FAIL call_lo_strobe: got we=%b a=%0d d=%h want 1/2046/0234", mem_write_enable, mem_address, mem_write_data); end
    idle_in();
    cyc();
    n_checks++; if (op_ready !== 1'b1 || sp_out !== 11'd2045) begin n_fail++; $display("FAIL call_done: got ready=%b sp=%0d want 1/2045", op_ready, sp_out); end
    n_checks++; if (mem[2047] !== 16'h0001 || mem[2046] !== 16'h0234) begin n_fail++; $display("FAIL call_mem: got [2047]=%h [2046]=%h want 0001/0234", mem[2047], mem[2046]); end
    drive(RET, '0, '0, '0);
    #1;
    n_checks++; if (mem_read_enable !== 1'b1 || mem_address !== 32'd2046) begin n_fail++; $display("FAIL ret_lo_strobe: got re=%b a=%0d want 1/2046", mem_read_enable, mem_address); end
    cyc();
    idle_in();
    #1;
    n_checks++; if (op_ready !== 1'b0 || mem_read_enable !== 1'b1 || mem_address !== 32'd2047) begin n_fail++; $display("FAIL ret_hi_strobe: got ready=%b re=%b a=%0d want 0/1/2047", op_ready, mem_read_enable, mem_address); end
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL ret_early_valid: got %b want 0", pc_valid); end
    cyc();
    n_checks++; if (pc_valid !== 1'b1 || pc_out !== 32'h0001_0234) begin n_fail++; $display("FAIL ret_pc: got v=%b pc=%h want 1/00010234", pc_valid, pc_out); end
    n_checks++; if (sp_out !== 11'd2047 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL ret_sp: got sp=%0d rd_valid=%b want 2047/0", sp_out, rd_valid); end
    cyc();
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL ret_valid_pulse: got %b want 0", pc_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    drive(STORE, 32'h10, 16'h5555, '0);
    #1;
    n_checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'h10 || mem_write_data !== 16'h5555) begin n_fail++; $display("FAIL store_strobe: got we=%b a=%h d=%h want 1/10/5555", mem_write_enable, mem_address, mem_write_data); end
    cyc();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_rd_valid: got %b want 0", rd_valid); end
    drive(LOAD, 32'h10, '0, '0);
    #1;
    n_checks++; if (mem_read_enable !== 1'b1 || mem_address !== 32'h10) begin n_fail++; $display("FAIL load_strobe: got re=%b a=%h want 1/10", mem_read_enable, mem_address); end
    cyc();
    idle_in();
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h5555) begin n_fail++; $display("FAIL load_data: got v=%b d=%h want 1/5555", rd_valid, rd_data); end
    n_checks++; if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL load_sp: got %0d want 2047", sp_out); end
    cyc();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_during_call();
    do_reset();
    drive(STORE, 32'd2046, 16'hDEAD, '0);
    cyc();
    drive(CALL, '0, '0, 32'hBEEF_1111);
    cyc();
    idle_in();
    rst = 1'b0;
    #1;
    n_checks++; if (mem_write_enable !== 1'b0 || op_ready !== 1'b0) begin n_fail++; $display("FAIL abort_call_strobe: got we=%b ready=%b want 0/0", mem_write_enable, op_ready); end
    cyc();
    n_checks++; if (sp_out !== 11'd2047) begin n_fail++; $display("FAIL abort_call_sp: got %0d want 2047", sp_out); end
    n_checks++; if (mem[2047] !== 16'hBEEF || mem[2046] !== 16'hDEAD) begin n_fail++; $display("FAIL abort_call_mem: got [2047]=%h [2046]=%h want beef/dead", mem[2047], mem[2046]); end
    rst = 1'b1;
    #1;
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL abort_call_ready: got %b want 1", op_ready); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_during_ret();
    do_reset();
    drive(CALL, '0, '0, 32'h1234_5678);
    cyc();
    idle_in();
    cyc();
    drive(RET, '0, '0, '0);
    cyc();
    idle_in();
    rst = 1'b0;
    cyc();
    n_checks++; if (pc_valid !== 1'b0 || sp_out !== 11'd2047 || pc_out !== 32'h0) begin n_fail++; $display("FAIL abort_ret: got v=%b sp=%0d pc=%h want 0/2047/0", pc_valid, sp_out, pc_out); end
    rst = 1'b1;
    cyc();
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL abort_ret_late_valid: got %b want 0", pc_valid); end
  endtask

  // ---------------------------------------------------------------------------
`ifdef STACK_BOUNDS_CHECK_EN
  task automatic test_bounds();
    do_reset();
    drive(POP, '0, '0, '0);
    #1;
    n_checks++; if (mem_read_enable !== 1'b0) begin n_fail++; $display("FAIL unf_strobe: got %b want 0", mem_read_enable); end
    cyc();
    idle_in();
    n_checks++; if (err_underflow !== 1'b1 || rd_valid !== 1'b0 || sp_out !== 11'd2047) begin n_fail++; $display("FAIL unf_pulse: got err=%b rd_valid=%b sp=%0d want 1/0/2047", err_underflow, rd_valid, sp_out); end
    cyc();
    n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_pulse_len: got %b want 0", err_underflow); end
    for (int i = 0; i < 2046; i++) begin
      drive(PUSH, '0, DW'(i), '0);
      cyc();
    end
    idle_in();
    n_checks++; if (sp_out !== 11'd1) begin n_fail++; $display("FAIL fill_sp: got %0d want 1", sp_out); end
    drive(CALL, '0, '0, 32'hCAFE_F00D);
    #1;
    n_checks++; if (mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL ovf_strobe: got %b want 0", mem_write_enable); end
    cyc();
    idle_in();
    n_checks++; if (err_overflow !== 1'b1 || sp_out !== 11'd1 || op_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got err=%b sp=%0d ready=%b want 1/1/1", err_overflow, sp_out, op_ready); end
    n_checks++; if (mem[1] === 16'hCAFE || mem[0] === 16'hF00D) begin n_fail++; $display("FAIL ovf_mem: got [1]=%h [0]=%h want untouched", mem[1], mem[0]); end
    cyc();
    n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_len: got %b want 0", err_overflow); end
  endtask
`else
  task automatic test_bounds();
    do_reset();
    drive(STORE, 32'd0, 16'h0F0F, '0);
    cyc();
    drive(POP, '0, '0, '0);
    #1;
    n_checks++; if (mem_read_enable !== 1'b1 || mem_address !== 32'd0) begin n_fail++; $display("FAIL wrap_pop_strobe: got re=%b a=%0d want 1/0", mem_read_enable, mem_address); end
    cyc();
    n_checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h0F0F || sp_out !== 11'd0 || err_underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_pop: got v=%b d=%h sp=%0d err=%b want 1/0f0f/0/0", rd_valid, rd_data, sp_out, err_underflow); end
    drive(PUSH, '0, 16'h7777, '0);
    #1;
    n_checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'd0) begin n_fail++; $display("FAIL wrap_push_strobe: got we=%b a=%0d want 1/0", mem_write_enable, mem_address); end
    cyc();
    idle_in();
    n_checks++; if (sp_out !== 11'd2047 || mem[0] !== 16'h7777 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_push: got sp=%0d mem0=%h err=%b want 2047/7777/0", sp_out, mem[0], err_overflow); end
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_push_pop();
    test_call_ret();
    test_back_to_back();
    test_reset_during_call();
    test_reset_during_ret();
    test_bounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
